// File: rtl/fifo_stream_reader.sv
// Drain side of the 8x8 synchronous FIFO: issues only safe reads against the stale
// status flags, absorbs the read latency in a 2-entry buffer, and frames bursts.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int PKT_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_re,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    input  logic                  fifo_almost_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [PKT_CNT_W-1:0]  pkt_count,
    output logic                  busy
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    logic                  rd_pend_q, rd_pend_d;
    logic [1:0]            occ_q, occ_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [BEAT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [PKT_CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic                  pop;
    logic                  push;
    logic                  read_safe;
    logic                  space_ok;

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = buf0_q;
    assign m_last    = m_valid && (beat_cnt_q == LAST_BEAT);
    assign pkt_count = pkt_count_q;
    assign busy      = rd_pend_q || m_valid;

    always_comb begin
        pop  = m_valid && m_ready;
        push = rd_pend_q;

        // Flags do not yet reflect last cycle's read, so near empty only read after an idle cycle.
        read_safe = !fifo_almost_empty || (!fifo_empty && !rd_pend_q);
        space_ok  = ({1'b0, occ_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, pop});
        fifo_re   = !rst && en && read_safe && space_ok;
        rd_pend_d = fifo_re;

        occ_d  = occ_q;
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_rdata;
                end else begin
                    buf1_d = fifo_rdata;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    buf0_d = fifo_rdata;
                end else begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_rdata;
                end
            end
            default: ;
        endcase

        beat_cnt_d  = beat_cnt_q;
        pkt_count_d = pkt_count_q;
        if (pop) begin
            if (beat_cnt_q == LAST_BEAT) begin
                beat_cnt_d  = '0;
                pkt_count_d = pkt_count_q + 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_q   <= 1'b0;
            occ_q       <= 2'd0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            beat_cnt_q  <= '0;
            pkt_count_q <= '0;
        end else begin
            rd_pend_q   <= rd_pend_d;
            occ_q       <= occ_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO plus a word-queue reference model,
// a cycle table for streaming, directed corner cases and a randomized run.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          fifo_re;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_almost_empty = 1'b1;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic [PW-1:0] pkt_count;
    logic          busy;

    logic          wr_en;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    int            beat_m = 0;
    logic [PW-1:0] pkt_m = '0;
    logic          prev_re_m = 1'b0;
    int            rd_total = 0;
    int            acc_total = 0;
    logic [DW-1:0] last_tag = '0;
    logic [DW-1:0] w;
    logic          ev;
    logic          chk_on = 1'b0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          re;
        logic          valid;
        logic [DW-1:0] data;
        logic          last;
        logic [PW-1:0] pkt;
    } vec_t;
    vec_t tbl[13];

    fifo_stream_reader #(.DATA_WIDTH(DW), .BURST_LEN(BL), .PKT_CNT_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .fifo_re(fifo_re), .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic r, input logic wv, input logic [DW-1:0] d);
        en      = e;
        m_ready = r;
        wr_en   = wv;
        wr_data = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // FIFO (flags registered from the new count) and the expected-word queue:
    // every word read joins exp_q and leaves it when the stream accepts it.
    always @(posedge clk) begin
        if (rst) begin
            fifo_mem.delete();
            exp_q.delete();
            beat_m    = 0;
            pkt_m     = '0;
            prev_re_m = 1'b0;
            fifo_empty        <= 1'b1;
            fifo_almost_empty <= 1'b1;
            fifo_rdata        <= '0;
        end else begin
            ev = exp_q.size() > (prev_re_m ? 1 : 0);
            if (ev && m_ready) begin
                acc_total++;
                if (m_last) last_tag = m_data;
                void'(exp_q.pop_front());
                if (beat_m == BL - 1) begin
                    beat_m = 0;
                    pkt_m  = pkt_m + 1'b1;
                end else begin
                    beat_m++;
                end
            end
            if (fifo_re) begin
                rd_total++;
                w = (fifo_mem.size() != 0) ? fifo_mem.pop_front() : 8'hEE;
                exp_q.push_back(w);
                fifo_rdata <= w;
            end
            prev_re_m = fifo_re;
            if (wr_en && fifo_mem.size() < 8) fifo_mem.push_back(wr_data);
            fifo_empty        <= (fifo_mem.size() == 0);
            fifo_almost_empty <= (fifo_mem.size() <= 2);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic exp_valid;
            logic pop;
            logic exp_re;
            exp_valid = exp_q.size() > (prev_re_m ? 1 : 0);
            pop       = exp_valid && m_ready;
            exp_re    = !rst && en && (!fifo_almost_empty || (!fifo_empty && !prev_re_m))
                        && ((exp_q.size() - (pop ? 1 : 0)) < 2);
            checkOutput("fifo_re", fifo_re, exp_re);
            checkOutput("underrun", fifo_re && (fifo_mem.size() == 0), 0);
            checkOutput("m_valid", m_valid, exp_valid);
            if (exp_valid) begin
                checkOutput("m_data", m_data, exp_q[0]);
                checkOutput("m_last", m_last, beat_m == BL - 1);
            end else begin
                checkOutput("m_last_idle", m_last, 0);
            end
            checkOutput("pkt_count", pkt_count, pkt_m);
            checkOutput("busy", busy, exp_q.size() != 0);
        end
    end

    initial begin
        int base_rd;
        int base_acc;
        int n;

        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h10, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 16'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h14, 1'b0, 16'd1};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 16'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 16'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd1};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h17, 1'b1, 16'd1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd2};

        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (2) tick();
        @(negedge clk);
        checkOutput("rst_fifo_re", fifo_re, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", m_data, 0);
        checkOutput("rst_m_last", m_last, 0);
        checkOutput("rst_pkt", pkt_count, 0);
        checkOutput("rst_busy", busy, 0);
        tick();
        rst    = 1'b0;
        chk_on = 1'b1;
        repeat (4) tick();
        checkOutput("idle_reads", rd_total, 0);

        $display("[TB] streaming table");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'h10 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        repeat (2) tick();
        base_rd = rd_total;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].en, tbl[i].rdy, 1'b0, '0);
            @(negedge clk);
            checkOutput($sformatf("tbl%0d_re", i), fifo_re, tbl[i].re);
            checkOutput($sformatf("tbl%0d_valid", i), m_valid, tbl[i].valid);
            if (tbl[i].valid) begin
                checkOutput($sformatf("tbl%0d_data", i), m_data, tbl[i].data);
                checkOutput($sformatf("tbl%0d_last", i), m_last, tbl[i].last);
            end
            checkOutput($sformatf("tbl%0d_pkt", i), pkt_count, tbl[i].pkt);
            tick();
        end
        checkOutput("stream_reads", rd_total - base_rd, 8);

        $display("[TB] near empty");
        base_acc = acc_total;
        last_tag = '0;
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hA1);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'hA2);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (10) tick();
        checkOutput("near_empty_beats", acc_total - base_acc, 2);
        checkOutput("near_empty_last", last_tag, 0);
        checkOutput("near_empty_pkt", pkt_count, 2);

        $display("[TB] backpressure");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h10 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        repeat (2) tick();
        base_rd = rd_total;
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (10) tick();
        @(negedge clk);
        checkOutput("bp_reads", rd_total - base_rd, 2);
        checkOutput("bp_m_data", m_data, 8'h10);
        checkOutput("bp_m_valid", m_valid, 1);
        tick();
        base_acc = acc_total;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (20) tick();
        checkOutput("bp_beats", acc_total - base_acc, 8);
        checkOutput("bp_pkt", pkt_count, 2);

        $display("[TB] mid-burst reset");
        base_acc = acc_total;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 8'hB0 + 8'(i));
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        n = 0;
        while (acc_total - base_acc < 2 && n < 30) begin
            tick();
            n++;
        end
        checkOutput("mid_wait_beats", acc_total - base_acc, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", m_valid, 0);
        checkOutput("mid_rst_pkt", pkt_count, 0);
        checkOutput("mid_rst_busy", busy, 0);
        tick();
        last_tag = '0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 8'hC0 + 8'(i));
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        repeat (20) tick();
        checkOutput("mid_new_last", last_tag, 8'hC3);
        checkOutput("mid_new_pkt", pkt_count, 1);

        $display("[TB] en gating");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 8'hD0 + 8'(i));
            tick();
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        repeat (2) tick();
        base_rd  = rd_total;
        base_acc = acc_total;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        n = 0;
        while (rd_total - base_rd < 3 && n < 20) begin
            tick();
            n++;
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        repeat (8) tick();
        checkOutput("en_off_reads", rd_total - base_rd, 3);
        checkOutput("en_off_beats", acc_total - base_acc, 3);
        last_tag = '0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        n = 0;
        while (acc_total - base_acc < 4 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("en_resume_last", last_tag, 8'hD3);
        checkOutput("en_resume_pkt", pkt_count, 2);
        repeat (15) tick();
        checkOutput("en_all_beats", acc_total - base_acc, 8);
        checkOutput("en_final_pkt", pkt_count, 3);

        $display("[TB] randomized run");
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            applyStimulus($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
                          ($urandom_range(0, 9) < 4) && (fifo_mem.size() < 8), 8'($urandom));
            tick();
        end
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        n = 0;
        while ((exp_q.size() != 0 || fifo_mem.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        checkOutput("drain_done", (exp_q.size() == 0) && (fifo_mem.size() == 0), 1);
        repeat (2) tick();
        checkOutput("drain_busy", busy, 0);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
